cache_controller: RTL and testbench
===================================

CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port cpu_req, input, 1 bit: CPU access request; sampled only while cpu_ready=1.
REQ-004 SHALL have port cpu_we, input, 1 bit: 1 = write, 0 = read.
REQ-005 SHALL have port cpu_addr, input, 5 bits: tag = [4:3], index = [2:0].
REQ-006 SHALL have port cpu_wdata, input, 8 bits: write data.
REQ-007 SHALL have port cpu_ready, output, 1 bit: controller idle and accepting requests.
REQ-008 SHALL have port cpu_done, output, 1 bit: one-cycle completion pulse.
REQ-009 SHALL have port cpu_rdata, output, 8 bits: read data; valid while cpu_done=1.
REQ-010 SHALL have ports hit and miss, outputs, 1 bit each: lookup result; one-cycle pulse in LOOKUP.
REQ-011 SHALL have ports mem_req and mem_we, outputs, 1 bit each: backing-memory request and direction.
REQ-012 SHALL have ports mem_addr (output, 5 bits), mem_wdata (output, 8 bits), mem_rdata (input, 8 bits) and mem_ack (input, 1 bit).
REQ-013 SHALL have ports hit_count and miss_count, outputs, 8 bits each: statistics counters.

Function
REQ-014 SHALL hold 2 ways x 8 sets; each entry holds valid, dirty, 2-bit tag and 8-bit data, plus 1 LRU bit per set that names the victim way.
REQ-015 SHALL implement FSM states IDLE, LOOKUP, WRITEBACK, FILL and DONE.
REQ-016 IDLE: cpu_ready=1; on cpu_req=1, SHALL latch cpu_we, cpu_addr and cpu_wdata, then go to LOOKUP; later input changes SHALL have no effect until the next acceptance.
REQ-017 LOOKUP: a hit is a valid entry whose tag matches; SHALL pulse hit, perform the access, set the set's LRU bit to the other way, pulse cpu_done and return to IDLE; hit latency is 2 cycles from acceptance.
REQ-018 Hit write SHALL store the data and set dirty; hit read SHALL drive the entry's data on cpu_rdata.
REQ-019 LOOKUP miss SHALL pulse miss and select the LRU victim way; if the victim is valid and dirty, go to WRITEBACK, otherwise go to FILL.
REQ-020 WRITEBACK SHALL assert mem_req=1, mem_we=1, mem_addr={victim tag,index}, mem_wdata=victim data, all held stable until mem_ack=1 is sampled, then go to FILL.
REQ-021 FILL SHALL assert mem_req=1, mem_we=0, mem_addr=latched address until mem_ack=1; on ack SHALL load mem_rdata into the victim with valid=1, dirty=0 and the new tag, then go to DONE.
REQ-022 DONE SHALL perform the access on the filled way (write-allocate: write data and set dirty=1), update the LRU bit, pulse cpu_done and return to IDLE.
REQ-023 mem_req SHALL be 0 outside WRITEBACK and FILL; mem_ack SHALL be ignored while mem_req=0.
REQ-024 mem_req SHALL drop in the cycle after ack; WRITEBACK to FILL SHALL re-assert mem_req only after at least one cycle with mem_req=0.
REQ-025 cpu_req SHALL be ignored while cpu_ready=0; no request queuing.
REQ-026 hit and miss SHALL never be 1 in the same cycle; cpu_rdata SHALL hold its last value when not updated.

Reset
REQ-027 resetn=0 SHALL immediately force IDLE and clear all valid, dirty and LRU bits, with cpu_ready=1, cpu_done=0, hit=0, miss=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rdata=0 and both counters 0.
REQ-028 Reset during WRITEBACK or FILL SHALL abandon the transfer; mem_req SHALL drop asynchronously and the pending access SHALL be discarded.

Configuration
REQ-029 When macro CACHE_STATS_EN is defined, hit_count and miss_count SHALL increment on each hit and miss pulse and saturate at 255.
REQ-030 When CACHE_STATS_EN is undefined, hit_count and miss_count SHALL be constant 0 with no counter logic; all other behaviour SHALL be identical.

Verification
REQ-031 After reset, read addr 5'b01_010 with mem_ack returned 2 cycles after mem_req and mem_rdata=8'hA5 -> miss, FILL only (no WRITEBACK), cpu_done with cpu_rdata=8'hA5; repeated read -> hit, cpu_rdata=8'hA5, cpu_done 2 cycles after acceptance.
REQ-032 Write 8'h3C to 5'b00_001 (miss, filled), then 5'b01_001 and 5'b10_001 -> third access evicts the LRU tag 00 way: WRITEBACK with mem_addr=5'b00_001 and mem_wdata=8'h3C, then FILL with mem_addr=5'b10_001.
REQ-033 cpu_req held high with changing cpu_addr during a miss -> ignored; exactly one cpu_done per accepted request.
REQ-034 resetn asserted mid-FILL with mem_req=1 -> mem_req=0 and cpu_ready=1 immediately; the next read of the same address misses.
REQ-035 With CACHE_STATS_EN: 300 hits -> hit_count=255; without the macro: hit_count=miss_count=0 throughout.

Source files
------------

// File: rtl/cache_controller.sv
// Two-way, eight-set write-back / write-allocate cache controller with an LRU bit per set.
// Optional hit/miss statistics counters are built only when CACHE_STATS_EN is defined.
module cache_controller (
  input  logic       clock,
  input  logic       resetn,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [4:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_ready,
  output logic       cpu_done,
  output logic [7:0] cpu_rdata,
  output logic       hit,
  output logic       miss,
  output logic       mem_req,
  output logic       mem_we,
  output logic [4:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ack,
  output logic [7:0] hit_count,
  output logic [7:0] miss_count
);

  localparam int unsigned Ways = 2;
  localparam int unsigned Sets = 8;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StWriteback,
    StFill,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic       we_q, we_d;
  logic [4:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       victim_q, victim_d;
  logic       gap_q, gap_d;
  logic       cpu_done_q, cpu_done_d;
  logic [7:0] cpu_rdata_q, cpu_rdata_d;

  logic [Ways-1:0][Sets-1:0]      valid_q, valid_d;
  logic [Ways-1:0][Sets-1:0]      dirty_q, dirty_d;
  logic [Ways-1:0][Sets-1:0][1:0] tag_q, tag_d;
  logic [Ways-1:0][Sets-1:0][7:0] data_q, data_d;
  logic [Sets-1:0]                lru_q, lru_d;

  logic [2:0] idx;
  logic [1:0] tag_in;
  logic       hit0, hit1, lookup_hit, hit_way;
  logic       lru_way;

  assign idx        = addr_q[2:0];
  assign tag_in     = addr_q[4:3];
  assign hit0       = valid_q[0][idx] && (tag_q[0][idx] == tag_in);
  assign hit1       = valid_q[1][idx] && (tag_q[1][idx] == tag_in);
  assign lookup_hit = hit0 || hit1;
  // Both ways can never hold the same tag, so way 0 winning is only a tie-break.
  assign hit_way    = ~hit0;
  assign lru_way    = lru_q[idx];

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    victim_d    = victim_q;
    gap_d       = 1'b0;
    cpu_done_d  = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    tag_d       = tag_q;
    data_d      = data_q;
    lru_d       = lru_q;
    cpu_ready   = 1'b0;
    hit         = 1'b0;
    miss        = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;

    unique case (state_q)
      StIdle: begin
        cpu_ready = 1'b1;
        if (cpu_req) begin
          we_d    = cpu_we;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          state_d = StLookup;
        end
      end

      StLookup: begin
        if (lookup_hit) begin
          hit = 1'b1;
          if (we_q) begin
            data_d[hit_way][idx]  = wdata_q;
            dirty_d[hit_way][idx] = 1'b1;
          end else begin
            cpu_rdata_d = data_q[hit_way][idx];
          end
          lru_d[idx] = ~hit_way;
          cpu_done_d = 1'b1;
          state_d    = StIdle;
        end else begin
          miss     = 1'b1;
          victim_d = lru_way;
          if (valid_q[lru_way][idx] && dirty_q[lru_way][idx]) begin
            state_d = StWriteback;
          end else begin
            state_d = StFill;
          end
        end
      end

      StWriteback: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_q[victim_q][idx], idx};
        mem_wdata = data_q[victim_q][idx];
        if (mem_ack) begin
          // Force one idle cycle on mem_req before the fill request goes out.
          gap_d   = 1'b1;
          state_d = StFill;
        end
      end

      StFill: begin
        mem_req  = ~gap_q;
        mem_addr = addr_q;
        if (!gap_q && mem_ack) begin
          valid_d[victim_q][idx] = 1'b1;
          dirty_d[victim_q][idx] = 1'b0;
          tag_d[victim_q][idx]   = tag_in;
          data_d[victim_q][idx]  = mem_rdata;
          state_d                = StDone;
        end
      end

      StDone: begin
        if (we_q) begin
          data_d[victim_q][idx]  = wdata_q;
          dirty_d[victim_q][idx] = 1'b1;
        end else begin
          cpu_rdata_d = data_q[victim_q][idx];
        end
        lru_d[idx] = ~victim_q;
        cpu_done_d = 1'b1;
        state_d    = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      victim_q    <= 1'b0;
      gap_q       <= 1'b0;
      cpu_done_q  <= 1'b0;
      cpu_rdata_q <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
      tag_q       <= '0;
      data_q      <= '0;
      lru_q       <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      victim_q    <= victim_d;
      gap_q       <= gap_d;
      cpu_done_q  <= cpu_done_d;
      cpu_rdata_q <= cpu_rdata_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
      lru_q       <= lru_d;
    end
  end

  assign cpu_done  = cpu_done_q;
  assign cpu_rdata = cpu_rdata_q;

`ifdef CACHE_STATS_EN
  logic [7:0] hit_cnt_q, hit_cnt_d;
  logic [7:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit && (hit_cnt_q != 8'hFF)) begin
      hit_cnt_d = hit_cnt_q + 8'd1;
    end
    if (miss && (miss_cnt_q != 8'hFF)) begin
      miss_cnt_d = miss_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Randomized bench for cache_controller: a flat golden memory plus a per-set tag/LRU model
// predicts hit/miss, writebacks, fills and read data; a backing-memory responder acks requests.
module tb_cache_controller;

  logic       clock = 1'b0;
  logic       resetn;
  logic       cpu_req;
  logic       cpu_we;
  logic [4:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_ready;
  logic       cpu_done;
  logic [7:0] cpu_rdata;
  logic       hit;
  logic       miss;
  logic       mem_req;
  logic       mem_we;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_ack;
  logic [7:0] hit_count;
  logic [7:0] miss_count;

`ifdef CACHE_STATS_EN
  localparam bit StatsOn = 1'b1;
`else
  localparam bit StatsOn = 1'b0;
`endif

  cache_controller dut (
    .clock      (clock),
    .resetn     (resetn),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ready  (cpu_ready),
    .cpu_done   (cpu_done),
    .cpu_rdata  (cpu_rdata),
    .hit        (hit),
    .miss       (miss),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: golden memory contents as the CPU sees them, and cache residency per set.
  logic [7:0] flat    [32];
  logic [7:0] mem_arr [32];
  bit         m_valid [2][8];
  bit         m_dirty [2][8];
  bit   [1:0] m_tag   [2][8];
  bit         m_lru   [8];
  int         exp_hits;
  int         exp_misses;

  function automatic void model_reset();
    for (int s = 0; s < 8; s++) begin
      m_lru[s] = 1'b0;
      for (int w = 0; w < 2; w++) begin
        m_valid[w][s] = 1'b0;
        m_dirty[w][s] = 1'b0;
        m_tag[w][s]   = 2'd0;
      end
    end
    // Dirty lines are lost on reset, so the CPU view falls back to backing memory.
    for (int a = 0; a < 32; a++) flat[a] = mem_arr[a];
    exp_hits   = 0;
    exp_misses = 0;
  endfunction

  task automatic check_stats();
    check_eq("hit_count", hit_count, StatsOn ? exp_hits : 0);
    check_eq("miss_count", miss_count, StatsOn ? exp_misses : 0);
  endtask

  // Called on a falling edge with cpu_ready=1; returns on a falling edge with cpu_ready=1.
  task automatic access(input bit we, input logic [4:0] addr, input logic [7:0] wd,
                        input int delay, input bit abort);
    logic [2:0] set;
    bit         exp_hit;
    bit         exp_wb;
    int         w;
    logic [4:0] exp_wb_addr;
    logic [7:0] exp_wb_data;
    logic [7:0] exp_rd;
    int         wb_n, fill_n, done_n, done_k, cnt;
    bit         ack_prev;
    bit         r_we;
    logic [4:0] r_addr;
    logic [7:0] r_wd;
    logic [4:0] got_wb_addr, got_fill_addr;
    logic [7:0] got_wb_data;

    set         = addr[2:0];
    exp_hit     = 1'b0;
    exp_wb      = 1'b0;
    w           = 0;
    exp_wb_addr = '0;
    exp_wb_data = '0;
    for (int i = 0; i < 2; i++) begin
      if (m_valid[i][set] && m_tag[i][set] == addr[4:3]) begin
        exp_hit = 1'b1;
        w       = i;
      end
    end
    if (!exp_hit) begin
      w = int'(m_lru[set]);
      if (m_valid[w][set] && m_dirty[w][set]) begin
        exp_wb      = 1'b1;
        exp_wb_addr = {m_tag[w][set], set};
        exp_wb_data = flat[exp_wb_addr];
      end
    end
    exp_rd = flat[addr];

    wb_n = 0; fill_n = 0; done_n = 0; done_k = 0; cnt = 0; ack_prev = 1'b0;
    r_we = 1'b0; r_addr = '0; r_wd = '0;
    got_wb_addr = '0; got_wb_data = '0; got_fill_addr = '0;

    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wd;

    for (int k = 1; k <= 60; k++) begin
      @(negedge clock);
      if (done_n > 0) begin
        check_eq("done_single", cpu_done, 0);
        check_eq("ready_after_done", cpu_ready, 1);
        break;
      end
      check_eq("hit_and_miss", hit & miss, 0);
      if (k == 1) begin
        check_eq("lookup_hit", hit, exp_hit);
        check_eq("lookup_miss", miss, !exp_hit);
        check_eq("lookup_busy", cpu_ready, 0);
        check_eq("lookup_no_mem", mem_req, 0);
      end else begin
        check_eq("late_lookup_pulse", hit | miss, 0);
      end
      mem_ack = 1'b0;
      if (ack_prev) begin
        check_eq("req_drop_after_ack", mem_req, 0);
        ack_prev = 1'b0;
      end
      if (cpu_done) begin
        done_n++;
        done_k = k;
        if (!we) check_eq("rdata", cpu_rdata, exp_rd);
      end
      if (mem_req) begin
        if (cnt == 0) begin
          r_we   = mem_we;
          r_addr = mem_addr;
          r_wd   = mem_wdata;
        end else begin
          check_eq("mem_stable", {mem_we, mem_addr, mem_wdata}, {r_we, r_addr, r_wd});
        end
        if (abort && !mem_we) begin
          resetn = 1'b0;
          #1;
          check_eq("abort_mem_req", mem_req, 0);
          check_eq("abort_ready", cpu_ready, 1);
          check_eq("abort_done", cpu_done, 0);
          check_eq("abort_mem_addr", mem_addr, 0);
          check_eq("abort_rdata", cpu_rdata, 0);
          check_eq("abort_hit_count", hit_count, 0);
          cpu_req = 1'b0;
          @(negedge clock);
          resetn = 1'b1;
          model_reset();
          return;
        end
        if (cnt == delay) begin
          mem_ack  = 1'b1;
          ack_prev = 1'b1;
          cnt      = 0;
          if (mem_we) begin
            wb_n++;
            got_wb_addr       = mem_addr;
            got_wb_data       = mem_wdata;
            mem_arr[mem_addr] = mem_wdata;
          end else begin
            fill_n++;
            got_fill_addr = mem_addr;
            mem_rdata     = mem_arr[mem_addr];
          end
        end else begin
          cnt++;
        end
      end else begin
        // Stray acks while no request is outstanding must be ignored.
        mem_ack   = ($urandom_range(0, 3) == 0);
        mem_rdata = 8'($urandom);
      end
      if (!cpu_ready) begin
        cpu_req   = 1'($urandom_range(0, 1));
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = 5'($urandom);
        cpu_wdata = 8'($urandom);
      end else begin
        cpu_req = 1'b0;
      end
    end
    mem_ack = 1'b0;
    cpu_req = 1'b0;

    check_eq("done_count", done_n, 1);
    if (exp_hit) check_eq("hit_latency", done_k, 2);
    check_eq("wb_count", wb_n, exp_wb);
    if (exp_wb) begin
      check_eq("wb_addr", got_wb_addr, exp_wb_addr);
      check_eq("wb_data", got_wb_data, exp_wb_data);
    end
    check_eq("fill_count", fill_n, !exp_hit);
    if (!exp_hit) check_eq("fill_addr", got_fill_addr, addr);

    if (exp_hit) begin
      if (exp_hits < 255) exp_hits++;
      if (we) m_dirty[w][set] = 1'b1;
    end else begin
      if (exp_misses < 255) exp_misses++;
      m_valid[w][set] = 1'b1;
      m_tag[w][set]   = addr[4:3];
      m_dirty[w][set] = we;
    end
    m_lru[set] = (w == 0);
    if (we) flat[addr] = wd;
    check_stats();
  endtask

  initial begin
    resetn    = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    for (int a = 0; a < 32; a++) mem_arr[a] = 8'($urandom);
    mem_arr[5'b01_010] = 8'hA5;
    model_reset();

    #1;
    check_eq("rst_ready", cpu_ready, 1);
    check_eq("rst_done", cpu_done, 0);
    check_eq("rst_hit_miss", {hit, miss}, 0);
    check_eq("rst_mem", {mem_req, mem_we, mem_addr, mem_wdata}, 0);
    check_eq("rst_rdata", cpu_rdata, 0);
    check_stats();
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);

    // Cold read miss then hit on the same line.
    access(1'b0, 5'b01_010, 8'h00, 1, 1'b0);
    access(1'b0, 5'b01_010, 8'h00, 1, 1'b0);
    // Dirty LRU eviction in set 1.
    access(1'b1, 5'b00_001, 8'h3C, 1, 1'b0);
    access(1'b1, 5'b01_001, 8'h5A, 1, 1'b0);
    access(1'b1, 5'b10_001, 8'hC3, 1, 1'b0);
    // Reset in the middle of a fill, then the same read must miss again.
    access(1'b0, 5'b11_111, 8'h00, 2, 1'b1);
    access(1'b0, 5'b11_111, 8'h00, 1, 1'b0);

    repeat (300) begin
      access(1'($urandom_range(0, 1)), 5'($urandom), 8'($urandom), $urandom_range(0, 3), 1'b0);
    end
    // Long run of hits to push the hit counter to saturation.
    repeat (300) access(1'b0, 5'b00_000, 8'h00, 0, 1'b0);
    check_eq("hit_count_final", hit_count, StatsOn ? 255 : 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
